// File: rtl/d_debounce.sv
// Two-flop synchronizer followed by a counter-qualified debounce FSM.
// Produces a clean level plus registered single-cycle rise/fall pulses.
module d_debounce #(
  parameter int unsigned STABLE_CNT = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    StIdleLow,
    StWaitHigh,
    StIdleHigh,
    StWaitLow
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic sync1_q, sync2_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Only sync2_q may feed the FSM; din is treated as fully asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdleLow;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      StIdleLow: begin
        if (sync2_q) begin
          state_d = StWaitHigh;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end

      StWaitHigh: begin
        if (!sync2_q) begin
          // Bounce back: drop the candidate and restart from scratch.
          state_d = StIdleLow;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdleHigh;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StIdleHigh: begin
        if (!sync2_q) begin
          state_d = StWaitLow;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end

      StWaitLow: begin
        if (sync2_q) begin
          state_d = StIdleHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdleLow;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        state_d = StIdleLow;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == StWaitHigh) || (state_q == StWaitLow);

endmodule

// File: tb/tb_d_debounce.sv
// Bench for d_debounce: window-based reference model checked every cycle,
// plus directed latency/count checks for each scenario.
module tb_d_debounce;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout, rise, fall, busy;

  int checks   = 0;
  int failures = 0;

  d_debounce #(
    .STABLE_CNT(N),
    .CNT_W     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: the FSM sees din two edges late; dout flips once the last N
  // samples it has seen all disagree with dout. Busy means the newest seen
  // sample disagrees with dout.
  logic [1:0]   m_syn;
  logic [N-1:0] m_win;
  logic         m_dout, m_rise, m_fall;
  logic         m_busy;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_syn  <= '0;
      m_win  <= '0;
      m_dout <= 1'b0;
      m_rise <= 1'b0;
      m_fall <= 1'b0;
    end else begin
      m_syn  <= {m_syn[0], din};
      m_win  <= {m_win[N-2:0], m_syn[1]};
      m_rise <= 1'b0;
      m_fall <= 1'b0;
      if ({m_win[N-2:0], m_syn[1]} == {N{~m_dout}}) begin
        m_dout <= ~m_dout;
        m_rise <= ~m_dout;
        m_fall <= m_dout;
      end
    end
  end

  assign m_busy = (m_win[0] != m_dout);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_dout", int'(dout), int'(m_dout));
    chk("model_rise", int'(rise), int'(m_rise));
    chk("model_fall", int'(fall), int'(m_fall));
    chk("model_busy", int'(busy), int'(m_busy));
    chk("rise_fall_excl", int'(rise & fall), 0);
  end

  // Step 'cycles' rising edges, sampling after each; first-seen times are 1-based.
  task automatic observe(input int cycles, output int n_rise, output int n_fall,
                         output int t_rise, output int t_fall, output int t_busy);
    n_rise = 0; n_fall = 0; t_rise = 0; t_fall = 0; t_busy = 0;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rise) begin
        n_rise++;
        if (t_rise == 0) t_rise = i;
      end
      if (fall) begin
        n_fall++;
        if (t_fall == 0) t_fall = i;
      end
      if (busy && t_busy == 0) t_busy = i;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, nf, tr, tf, tb;
    int tot_r;

    // Reset held with din high: outputs stay low.
    rst = 1'b0;
    din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_dout", int'(dout), 0);
      chk("rst_rise", int'(rise), 0);
      chk("rst_fall", int'(fall), 0);
      chk("rst_busy", int'(busy), 0);
    end
    rst = 1'b1;
    observe(14, nr, nf, tr, tf, tb);
    chk("rst_rel_t_rise", tr, 10);
    chk("rst_rel_n_rise", nr, 1);
    chk("rst_rel_n_fall", nf, 0);
    chk("rst_rel_dout", int'(dout), 1);

    // Clean fall.
    din = 1'b0;
    observe(14, nr, nf, tr, tf, tb);
    chk("fall_t_fall", tf, 10);
    chk("fall_n_fall", nf, 1);
    chk("fall_n_rise", nr, 0);
    chk("fall_t_busy", tb, 3);
    chk("fall_dout", int'(dout), 0);

    // Clean rise.
    din = 1'b1;
    observe(14, nr, nf, tr, tf, tb);
    chk("rise_t_busy", tb, 3);
    chk("rise_t_rise", tr, 10);
    chk("rise_n_rise", nr, 1);
    chk("rise_n_fall", nf, 0);
    chk("rise_dout", int'(dout), 1);
    din = 1'b0;
    observe(14, nr, nf, tr, tf, tb);
    chk("rise_ret_n_fall", nf, 1);

    // Glitch of 5 samples is rejected.
    din = 1'b1;
    observe(5, nr, nf, tr, tf, tb);
    tot_r = nr;
    chk("glitch_t_busy", tb, 3);
    din = 1'b0;
    observe(14, nr, nf, tr, tf, tb);
    tot_r += nr;
    chk("glitch_n_rise", tot_r, 0);
    chk("glitch_n_fall", nf, 0);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_dout", int'(dout), 0);

    // Bounce 1,0,1,0 at 3-cycle intervals, then settle high.
    tot_r = 0;
    for (int k = 0; k < 4; k++) begin
      din = (k % 2 == 0) ? 1'b1 : 1'b0;
      observe(3, nr, nf, tr, tf, tb);
      tot_r += nr;
    end
    chk("bounce_early_rise", tot_r, 0);
    din = 1'b1;
    observe(14, nr, nf, tr, tf, tb);
    chk("bounce_t_rise", tr, 10);
    chk("bounce_n_rise", nr, 1);
    chk("bounce_dout", int'(dout), 1);

    // Reset mid-qualification discards the partial count.
    din = 1'b0;
    observe(14, nr, nf, tr, tf, tb);
    chk("pre_midrst_dout", int'(dout), 0);
    din = 1'b1;
    observe(7, nr, nf, tr, tf, tb);
    chk("midrst_busy_before", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_rise", int'(rise), 0);
    chk("midrst_fall", int'(fall), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    observe(14, nr, nf, tr, tf, tb);
    chk("midrst_t_rise", tr, 10);
    chk("midrst_n_rise", nr, 1);
    chk("midrst_dout_end", int'(dout), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
